// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/result handshake and full-adder cell connections for serial_adder_ctrl
interface serial_adder_ctrl_if #(
  parameter int N = 8
);
  logic         i_start;
  logic [N-1:0] i_A;
  logic [N-1:0] i_B;
  logic         i_Cin;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_S;
  logic         o_Cout;
  logic         o_fa_A;
  logic         o_fa_B;
  logic         o_fa_Cin;
  logic         i_fa_S;
  logic         i_fa_Cout;

  modport slave (
    input  i_start, i_A, i_B, i_Cin, i_fa_S, i_fa_Cout,
    output o_busy, o_done, o_S, o_Cout, o_fa_A, o_fa_B, o_fa_Cin
  );

  modport master (
    output i_start, i_A, i_B, i_Cin, i_fa_S, i_fa_Cout,
    input  o_busy, o_done, o_S, o_Cout, o_fa_A, o_fa_B, o_fa_Cin
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial N-bit adder sequencer driving one external full-adder cell
module serial_adder_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  serial_adder_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  sum_sh;
  logic [N-1:0]  s_q;
  logic          cout_q;
  logic          run;
  logic          last;

  assign run  = (state == S_RUN);
  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            a_sh  <= bus.i_A;
            b_sh  <= bus.i_B;
            carry <= bus.i_Cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum_sh <= {bus.i_fa_S, sum_sh[N-1:1]};
          carry  <= bus.i_fa_Cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          // Final bit: publish the sum straight from the cell output, bypassing sum_sh
          if (last) begin
            s_q    <= {bus.i_fa_S, sum_sh[N-1:1]};
            cout_q <= bus.i_fa_Cout;
            cnt    <= '0;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy   = run;
  assign bus.o_done   = (state == S_DONE);
  assign bus.o_S      = s_q;
  assign bus.o_Cout   = cout_q;
  assign bus.o_fa_A   = run & a_sh[0];
  assign bus.o_fa_B   = run & b_sh[0];
  assign bus.o_fa_Cin = run & carry;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized and directed bench for serial_adder_ctrl at N=8 and exhaustive N=4
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.N(8)) if8 ();
  serial_adder_ctrl_if #(.N(4)) if4 ();

  // Behavioural full-adder cells shared by each sequencer
  assign if8.i_fa_S    = if8.o_fa_A ^ if8.o_fa_B ^ if8.o_fa_Cin;
  assign if8.i_fa_Cout = (if8.o_fa_A & if8.o_fa_B) | (if8.o_fa_Cin & (if8.o_fa_A ^ if8.o_fa_B));
  assign if4.i_fa_S    = if4.o_fa_A ^ if4.o_fa_B ^ if4.o_fa_Cin;
  assign if4.i_fa_Cout = (if4.o_fa_A & if4.o_fa_B) | (if4.o_fa_Cin & (if4.o_fa_A ^ if4.o_fa_B));

  serial_adder_ctrl #(.N(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(if8.slave));
  serial_adder_ctrl #(.N(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(if4.slave));

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference for the N=8 instance: cycles of RUN left, pending result, latched operands
  int m_left = 0;
  int m_done = 0;
  int m_s    = 0;
  int m_cout = 0;
  int m_a    = 0;
  int m_b    = 0;
  int m_cin  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 0;
      m_s    = 0;
      m_cout = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_s    = (m_a + m_b + m_cin) & 255;
        m_cout = (m_a + m_b + m_cin) >> 8;
      end
    end else if (if8.i_start) begin
      m_left = 8;
      m_a    = int'(if8.i_A);
      m_b    = int'(if8.i_B);
      m_cin  = int'(if8.i_Cin);
    end
  end

  int prev_busy4 = 0;
  int prev_cout4 = 0;

  always @(negedge clk) begin
    int j, mask, ea, eb, ec;
    if (chk_en) begin
      chk("busy", int'(if8.o_busy), int'(m_left > 0));
      chk("done", int'(if8.o_done), m_done);
      chk("S", int'(if8.o_S), m_s);
      chk("Cout", int'(if8.o_Cout), m_cout);
      if (m_left > 0) begin
        j    = 8 - m_left;
        mask = (1 << j) - 1;
        ea   = (m_a >> j) & 1;
        eb   = (m_b >> j) & 1;
        ec   = ((m_a & mask) + (m_b & mask) + m_cin) >> j;
      end else begin
        ea = 0; eb = 0; ec = 0;
      end
      chk("fa_A", int'(if8.o_fa_A), ea);
      chk("fa_B", int'(if8.o_fa_B), eb);
      chk("fa_Cin", int'(if8.o_fa_Cin), ec);
      if (!if4.o_busy)
        chk("fa4_idle", int'({if4.o_fa_A, if4.o_fa_B, if4.o_fa_Cin}), 0);
      else if (prev_busy4 != 0)
        chk("fa4_carry", int'(if4.o_fa_Cin), prev_cout4);
    end
    prev_busy4 = int'(if4.o_busy);
    prev_cout4 = int'(if4.i_fa_Cout);
  end

  task automatic run8(input int a, input int b, input int c, input int exp);
    int k, nbusy;
    bit seen;
    @(negedge clk); #1;
    if8.i_start = 1'b1; if8.i_A = 8'(a); if8.i_B = 8'(b); if8.i_Cin = 1'(c);
    @(negedge clk); #1;
    if8.i_start = 1'b0; if8.i_A = 8'($urandom); if8.i_B = 8'($urandom); if8.i_Cin = 1'($urandom);
    nbusy = int'(if8.o_busy);
    k = 0; seen = 1'b0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (if8.o_done) seen = 1'b1;
      else nbusy += int'(if8.o_busy);
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("latency", k, 8);
    chk("busy_cycles", nbusy, 8);
    chk("sum8", int'({if8.o_Cout, if8.o_S}), exp);
  endtask

  task automatic run4(input int a, input int b, input int c);
    int k;
    bit seen;
    @(negedge clk); #1;
    if4.i_start = 1'b1; if4.i_A = 4'(a); if4.i_B = 4'(b); if4.i_Cin = 1'(c);
    @(negedge clk); #1;
    if4.i_start = 1'b0; if4.i_A = 4'($urandom); if4.i_B = 4'($urandom);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (if4.o_done) seen = 1'b1;
    end
    if (!seen) chk("done4_timeout", 0, 1);
    chk("sum4", int'({if4.o_Cout, if4.o_S}), a + b + c);
  endtask

  initial begin
    int t, last_t, nops, a, b, c;
    bit seen;
    if8.i_start = 1'b0; if8.i_A = '0; if8.i_B = '0; if8.i_Cin = 1'b0;
    if4.i_start = 1'b0; if4.i_A = '0; if4.i_B = '0; if4.i_Cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(if8.o_busy), 0);
    chk("rst_done", int'(if8.o_done), 0);
    chk("rst_S", int'({if8.o_Cout, if8.o_S}), 0);
    chk("rst_fa", int'({if8.o_fa_A, if8.o_fa_B, if8.o_fa_Cin}), 0);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    run8(8'h5A, 8'h3C, 0, 9'h096);
    run8(8'hFF, 8'h01, 0, 9'h100);
    run8(8'hFF, 8'hFF, 1, 9'h1FF);

    // Start held high: operands scrambled during RUN, restored before each acceptance
    @(negedge clk); #1;
    if8.i_start = 1'b1; if8.i_A = 8'h01; if8.i_B = 8'h02; if8.i_Cin = 1'b0;
    last_t = -1; nops = 0;
    for (t = 1; t <= 46; t++) begin
      @(negedge clk);
      if (if8.o_done) begin
        chk("held_sum", int'({if8.o_Cout, if8.o_S}), 9'h003);
        if (last_t >= 0) chk("held_spacing", t - last_t, 10);
        last_t = t;
        nops++;
      end
      #1;
      if (if8.o_busy) begin
        if8.i_A = 8'($urandom); if8.i_B = 8'($urandom);
      end else begin
        if8.i_A = 8'h01; if8.i_B = 8'h02;
      end
    end
    chk("held_ops", nops, 4);
    if8.i_start = 1'b0;
    repeat (15) @(negedge clk);

    // Reset in the middle of a run discards it
    #1 if8.i_start = 1'b1; if8.i_A = 8'h10; if8.i_B = 8'h20; if8.i_Cin = 1'b0;
    @(negedge clk); #1 if8.i_start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(if8.o_busy), 0);
    chk("midrst_done", int'(if8.o_done), 0);
    chk("midrst_S", int'({if8.o_Cout, if8.o_S}), 0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (if8.o_done) seen = 1'b1;
    end
    chk("midrst_no_done", int'(seen), 0);
    run8(8'h7F, 8'h01, 0, 9'h080);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 1));
      run8(a, b, c, a + b + c);
    end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int z = 0; z < 2; z++)
          run4(x, y, z);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
